// File: rtl/pfiform_join_arb.sv
// Round-robin join scheduler: grants one producer at a time onto the PFIFORM
// join port, streaming its burst under JoinPermit backpressure.
module pfiform_join_arb #(
  parameter int NUM_SRC = 4,
  parameter int DATA_W  = 96,
  parameter int LEN_W   = 8
) (
  input  logic                      i_core_clk,
  input  logic                      i_rx_rst,
  input  logic [NUM_SRC-1:0]        i_src_req,
  input  logic [4*NUM_SRC-1:0]      i_src_amount,
  input  logic [LEN_W*NUM_SRC-1:0]  i_src_len,
  input  logic [DATA_W*NUM_SRC-1:0] i_src_data,
  output logic [NUM_SRC-1:0]        o_src_ack,
  output logic [NUM_SRC-1:0]        o_src_done,
  output logic [NUM_SRC-1:0]        o_grant,
  output logic                      o_join_enable,
  output logic [3:0]                o_join_amount,
  output logic [DATA_W-1:0]         o_join_data,
  input  logic                      i_join_permit,
  output logic                      o_busy,
  output logic                      o_cfg_err
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e               state_q;
  logic [NUM_SRC-1:0]   grant_q;
  logic [NUM_SRC-1:0]   done_q;
  logic [IDX_W-1:0]     gidx_q;
  logic [IDX_W-1:0]     rr_ptr_q;
  logic [3:0]           amount_q;
  logic [LEN_W-1:0]     cnt_q;
  logic                 enable_q;
  logic                 busy_q;
  logic                 cfg_err_q;

  logic [3:0]           amt_a [NUM_SRC];
  logic [LEN_W-1:0]     len_a [NUM_SRC];
  logic [NUM_SRC-1:0]   elig_s;
  logic [NUM_SRC-1:0]   illegal_s;
  logic [NUM_SRC-1:0]   sel_grant_s;
  logic                 sel_found_s;
  logic [IDX_W-1:0]     sel_idx_s;
  logic [IDX_W-1:0]     probe_s;
  logic                 xfer_s;
  logic [DATA_W-1:0]    data_s;

  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      amt_a[i]     = i_src_amount[4*i +: 4];
      len_a[i]     = i_src_len[LEN_W*i +: LEN_W];
      elig_s[i]    = i_src_req[i] & (amt_a[i] != 4'd0) & (len_a[i] != LEN_W'(0));
      illegal_s[i] = i_src_req[i] & ((amt_a[i] == 4'd0) | (len_a[i] == LEN_W'(0)));
    end
  end

  // Walk downward so the eligible producer closest to rr_ptr is the last one written.
  always_comb begin
    sel_found_s = 1'b0;
    sel_idx_s   = '0;
    sel_grant_s = '0;
    probe_s     = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      probe_s = IDX_W'((int'(rr_ptr_q) + i) % NUM_SRC);
      if (elig_s[probe_s]) begin
        sel_found_s          = 1'b1;
        sel_idx_s            = probe_s;
        sel_grant_s          = '0;
        sel_grant_s[probe_s] = 1'b1;
      end else begin
        sel_found_s = sel_found_s;
      end
    end
  end

  always_comb begin
    data_s = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (grant_q[i]) begin
        data_s = data_s | i_src_data[DATA_W*i +: DATA_W];
      end else begin
        data_s = data_s;
      end
    end
  end

  assign xfer_s = enable_q & i_join_permit;

  always_ff @(posedge i_core_clk or posedge i_rx_rst) begin
    if (i_rx_rst) begin
      state_q   <= ST_IDLE;
      grant_q   <= '0;
      done_q    <= '0;
      gidx_q    <= '0;
      rr_ptr_q  <= '0;
      amount_q  <= 4'd0;
      cnt_q     <= '0;
      enable_q  <= 1'b0;
      busy_q    <= 1'b0;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_err_q | (|illegal_s);
      done_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (sel_found_s) begin
            state_q  <= ST_XFER;
            grant_q  <= sel_grant_s;
            gidx_q   <= sel_idx_s;
            amount_q <= amt_a[sel_idx_s];
            cnt_q    <= len_a[sel_idx_s];
            enable_q <= 1'b1;
            busy_q   <= 1'b1;
          end
        end
        ST_XFER: begin
          if (xfer_s) begin
            cnt_q <= cnt_q - LEN_W'(1);
            if (cnt_q == LEN_W'(1)) begin
              state_q  <= ST_DONE;
              enable_q <= 1'b0;
              done_q   <= grant_q;
            end
          end
        end
        ST_DONE: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          busy_q   <= 1'b0;
          rr_ptr_q <= (gidx_q == IDX_W'(NUM_SRC - 1)) ? '0 : gidx_q + IDX_W'(1);
        end
        default: begin
          state_q  <= ST_IDLE;
          grant_q  <= '0;
          enable_q <= 1'b0;
          busy_q   <= 1'b0;
        end
      endcase
    end
  end

  assign o_src_ack     = xfer_s ? grant_q : '0;
  assign o_src_done    = done_q;
  assign o_grant       = grant_q;
  assign o_join_enable = enable_q;
  assign o_join_amount = amount_q;
  assign o_join_data   = data_s;
  assign o_busy        = busy_q;
  assign o_cfg_err     = cfg_err_q;

endmodule
